v810_bus_ctl: RTL

External bus controller for the V810 core. It sits directly downstream of the execution core's data memory port (DA/DD_O/BEn/ST/MRQn/RW) and turns each single-cycle core request into a V810-style external bus cycle. The cycle has a BCYSTn start strobe, READYn wait states and SZRQn 16-bit dynamic bus sizing. Read data returns to the core with a one-cycle ACK pulse, and BUSY stalls the core while a cycle is in flight.

---
 rtl/v810_bus_ctl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/v810_bus_ctl.sv
// V810 external bus controller: turns single-cycle core data requests into
// BCYSTn/READYn bus cycles with 16-bit dynamic bus sizing and an ACK pulse.
module v810_bus_ctl (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] REQ_A,
  input  logic [31:0] REQ_DO,
  input  logic [3:0]  REQ_BEn,
  input  logic [1:0]  REQ_ST,
  input  logic        REQ_MRQn,
  input  logic        REQ_RW,
  output logic [31:0] REQ_DI,
  output logic        ACK,
  output logic        BUSY,
  output logic [31:0] A,
  input  logic [31:0] D_I,
  output logic [31:0] D_O,
  output logic        D_OE,
  output logic [3:0]  BEn,
  output logic [1:0]  ST,
  output logic        BCYSTn,
  output logic        MRQn,
  output logic        RW,
  input  logic        READYn,
  input  logic        SZRQn
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T1H,
    S_T2H,
    S_DONE
  } state_t;

  state_t r_state, w_nstate;

  // Request latch
  logic [31:0] r_la;
  logic [31:0] r_ldo;
  logic [3:0]  r_lben;
  logic        r_lrw;
  logic [15:0] r_lo16;

  // Registered bus outputs
  logic [31:0] r_a, r_do, r_req_di;
  logic [3:0]  r_ben;
  logic [1:0]  r_st;
  logic        r_bcystn, r_mrqn, r_rw, r_doe;

  logic        w_accept, w_sized;
  logic [31:0] w_a, w_do;
  logic [3:0]  w_ben;
  logic [1:0]  w_st;
  logic        w_bcystn, w_mrqn, w_rw, w_doe;

  always_comb begin
    w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && !REQ_MRQn;
    w_sized  = !SZRQn && (r_lben[1:0] != 2'b11) && (r_lben[3:2] != 2'b11);
    w_nstate = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_nstate = w_accept ? S_T1 : S_IDLE;
      S_T1:           w_nstate = S_T2;
      S_T2:           if (!READYn) w_nstate = w_sized ? S_T1H : S_DONE;
      S_T1H:          w_nstate = S_T2H;
      S_T2H:          if (!READYn) w_nstate = S_DONE;
      default:        w_nstate = S_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered and registered with it,
  // so A/ST/D_O simply keep whatever they last carried once the bus goes idle.
  always_comb begin
    w_a      = r_a;
    w_do     = r_do;
    w_ben    = r_ben;
    w_st     = r_st;
    w_bcystn = 1'b1;
    w_mrqn   = r_mrqn;
    w_rw     = r_rw;
    w_doe    = r_doe;
    case (w_nstate)
      S_T1: begin
        w_a      = REQ_A;
        w_ben    = REQ_BEn;
        w_st     = REQ_ST;
        w_rw     = REQ_RW;
        w_bcystn = 1'b0;
        w_mrqn   = 1'b0;
        w_doe    = !REQ_RW;
        if (!REQ_RW) w_do = REQ_DO;
      end
      S_T1H: begin
        w_a      = r_la | 32'h0000_0002;
        w_ben    = {2'b11, r_lben[3:2]};
        w_bcystn = 1'b0;
        if (!r_lrw) w_do = {r_ldo[31:16], r_ldo[31:16]};
      end
      S_T2, S_T2H: begin
      end
      default: begin
        w_mrqn = 1'b1;
        w_rw   = 1'b1;
        w_doe  = 1'b0;
        w_ben  = 4'hF;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state <= S_IDLE;
    end else if (CE) begin
      r_state <= w_nstate;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_la     <= '0;
      r_ldo    <= '0;
      r_lben   <= '1;
      r_lrw    <= 1'b1;
      r_lo16   <= '0;
      r_a      <= '0;
      r_do     <= '0;
      r_req_di <= '0;
      r_ben    <= '1;
      r_st     <= '0;
      r_bcystn <= 1'b1;
      r_mrqn   <= 1'b1;
      r_rw     <= 1'b1;
      r_doe    <= 1'b0;
    end else if (CE) begin
      r_a      <= w_a;
      r_do     <= w_do;
      r_ben    <= w_ben;
      r_st     <= w_st;
      r_bcystn <= w_bcystn;
      r_mrqn   <= w_mrqn;
      r_rw     <= w_rw;
      r_doe    <= w_doe;
      if (w_accept) begin
        r_la   <= REQ_A;
        r_ldo  <= REQ_DO;
        r_lben <= REQ_BEn;
        r_lrw  <= REQ_RW;
      end
      if ((r_state == S_T2) && !READYn) begin
        if (w_sized)    r_lo16   <= D_I[15:0];
        else if (r_lrw) r_req_di <= D_I;
      end
      if ((r_state == S_T2H) && !READYn && r_lrw) r_req_di <= {D_I[15:0], r_lo16};
    end
  end

  assign REQ_DI = r_req_di;
  assign ACK    = (r_state == S_DONE);
  assign BUSY   = (r_state == S_T1) || (r_state == S_T2) ||
                  (r_state == S_T1H) || (r_state == S_T2H);
  assign A      = r_a;
  assign D_O    = r_do;
  assign D_OE   = r_doe;
  assign BEn    = r_ben;
  assign ST     = r_st;
  assign BCYSTn = r_bcystn;
  assign MRQn   = r_mrqn;
  assign RW     = r_rw;

endmodule
